// File: rtl/wb_regfile_hilo_if.sv
// Write-back bus into the register file: GPR/HI-LO write requests, ID read ports and EX HI/LO view.
// The master drives writes and read requests; the slave (register file) returns the read data.
interface wb_regfile_hilo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              whilo;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [CNT_W-1:0]  wb_cnt;

  modport master (
    output we, waddr, wdata, whilo, hi_i, lo_i, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, wb_cnt
  );

  modport slave (
    input  we, waddr, wdata, whilo, hi_i, lo_i, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o, wb_cnt
  );
endinterface

// File: rtl/wb_regfile_hilo.sv
// Write-back GPR file (r0 hardwired to zero), HI/LO pair and committed-writeback counter.
// Define REGFILE_WB_BYPASS_EN to forward the presented write data to the read ports and HI/LO outputs.
module wb_regfile_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              rst,
  wb_regfile_hilo_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  // Flops rather than RAM: every entry must clear asynchronously on reset.
  logic [DATA_W-1:0] gpr_reg [1:DEPTH-1];
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic [CNT_W-1:0]  wb_cnt_reg;
  logic              gpr_wr;

  logic              rd_en   [2];
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign gpr_wr = bus.we && (bus.waddr != '0);

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_gpr
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          gpr_reg[gi] <= '0;
        end else if (gpr_wr && (bus.waddr == ADDR_W'(gi))) begin
          gpr_reg[gi] <= bus.wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (bus.whilo) begin
      hi_reg <= bus.hi_i;
      lo_reg <= bus.lo_i;
    end
  end

  // A cycle carrying both a GPR and a HI/LO write is one committed writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_cnt_reg <= '0;
    end else if (gpr_wr || bus.whilo) begin
      wb_cnt_reg <= wb_cnt_reg + CNT_W'(1);
    end
  end

  assign rd_en[0]   = bus.re1;
  assign rd_addr[0] = bus.raddr1;
  assign rd_en[1]   = bus.re2;
  assign rd_addr[1] = bus.raddr2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = '0;
        if (rd_en[gi] && (rd_addr[gi] != '0)) begin
`ifdef REGFILE_WB_BYPASS_EN
          // Forwarding is gated by rst so the ports read zero while reset is held.
          if (rst && gpr_wr && (bus.waddr == rd_addr[gi])) begin
            rd_data[gi] = bus.wdata;
          end else begin
            rd_data[gi] = gpr_reg[rd_addr[gi]];
          end
`else
          rd_data[gi] = gpr_reg[rd_addr[gi]];
`endif
        end
      end
    end
  endgenerate

  assign bus.rdata1 = rd_data[0];
  assign bus.rdata2 = rd_data[1];
  assign bus.wb_cnt = wb_cnt_reg;

`ifdef REGFILE_WB_BYPASS_EN
  assign bus.hi_o = (rst && bus.whilo) ? bus.hi_i : hi_reg;
  assign bus.lo_o = (rst && bus.whilo) ? bus.lo_i : lo_reg;
`else
  assign bus.hi_o = hi_reg;
  assign bus.lo_o = lo_reg;
`endif
endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Bench for wb_regfile_hilo: directed steps plus random traffic against an array-based model.
// A second instance with a 3-bit counter exercises the counter wrap.
module tb_wb_regfile_hilo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_hilo_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
  wb_regfile_hilo_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(3))  sbus ();

  wb_regfile_hilo #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  wb_regfile_hilo #(.DATA_W(32), .ADDR_W(5), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_cnt;
  int          s_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi  = '0;
    m_lo  = '0;
    m_cnt = '0;
    s_cnt = 0;
  endtask

  // Expected read value from the architectural rules, including optional forwarding.
  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
    if (!rst || !re || ra == 5'd0) return 32'd0;
`ifdef REGFILE_WB_BYPASS_EN
    if (bus.we && bus.waddr == ra) return bus.wdata;
`endif
    return m_gpr[ra];
  endfunction

  function automatic logic [31:0] exp_hi();
`ifdef REGFILE_WB_BYPASS_EN
    if (rst && bus.whilo) return bus.hi_i;
`endif
    return m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
`ifdef REGFILE_WB_BYPASS_EN
    if (rst && bus.whilo) return bus.lo_i;
`endif
    return m_lo;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/rdata1"}, bus.rdata1, exp_read(bus.re1, bus.raddr1));
    check({tag, "/rdata2"}, bus.rdata2, exp_read(bus.re2, bus.raddr2));
    check({tag, "/hi_o"},   bus.hi_o,   exp_hi());
    check({tag, "/lo_o"},   bus.lo_o,   exp_lo());
    check({tag, "/wb_cnt"}, bus.wb_cnt, m_cnt);
    check({tag, "/small_cnt"}, 32'(sbus.wb_cnt), 32'(s_cnt));
  endtask

  task automatic set_wr(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    bus.we = we; bus.waddr = wa; bus.wdata = wd;
    bus.whilo = whilo; bus.hi_i = hi; bus.lo_i = lo;
  endtask

  task automatic set_rd(input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2);
    bus.re1 = re1; bus.raddr1 = ra1; bus.re2 = re2; bus.raddr2 = ra2;
  endtask

  // Inputs are applied 1 time unit after a rising edge; checks land mid-cycle.
  task automatic step(input string tag);
    #2;
    check_all(tag);
    $display("step %-10s we=%0b waddr=%0d wdata=%08h whilo=%0b rd1=%08h rd2=%08h cnt=%0d",
             tag, bus.we, bus.waddr, bus.wdata, bus.whilo, bus.rdata1, bus.rdata2, bus.wb_cnt);
    @(posedge clk);
    if (bus.we && bus.waddr != 5'd0) m_gpr[bus.waddr] = bus.wdata;
    if (bus.whilo) begin
      m_hi = bus.hi_i;
      m_lo = bus.lo_i;
    end
    if ((bus.we && bus.waddr != 5'd0) || bus.whilo) m_cnt = m_cnt + 32'd1;
    if ((sbus.we && sbus.waddr != 5'd0) || sbus.whilo) s_cnt = (s_cnt + 1) % 8;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt_before;
    model_clear();
    set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);
    sbus.we = 1'b0; sbus.waddr = 5'd0; sbus.wdata = 32'd0;
    sbus.whilo = 1'b0; sbus.hi_i = 32'd0; sbus.lo_i = 32'd0;
    sbus.re1 = 1'b0; sbus.raddr1 = 5'd0; sbus.re2 = 1'b0; sbus.raddr2 = 5'd0;
    #1;
    check_all("reset0");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset clears state asynchronously, and a write presented under reset is lost.
    set_wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'd1, 32'd2);
    set_rd(1'b1, 5'd5, 1'b1, 5'd5);
    step("t1_wr");
    set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step("t1_vis");
    set_wr(1'b1, 5'd5, 32'h55, 1'b1, 32'd3, 32'd4);
    #2;
    rst = 1'b0;
    #1;
    check("t1_async/rdata1", bus.rdata1, 32'd0);
    check("t1_async/hi_o",   bus.hi_o,   32'd0);
    check("t1_async/lo_o",   bus.lo_o,   32'd0);
    check("t1_async/wb_cnt", bus.wb_cnt, 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    check_all("t1_held");
    set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    step("t1_rel");

    // Basic write and read, port enable gating.
    set_wr(1'b1, 5'd7, 32'h12345678, 1'b0, 32'd0, 32'd0);
    set_rd(1'b1, 5'd7, 1'b0, 5'd7);
    step("t2_wr");
    set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    #1;
    check("t2_lit/rdata1", bus.rdata1, 32'h12345678);
    check("t2_lit/wb_cnt", bus.wb_cnt, 32'd1);
    step("t2_rd");
    set_rd(1'b0, 5'd7, 1'b1, 5'd7);
    step("t2_re0");

    // Register 0 ignores writes and does not count.
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0);
    set_rd(1'b1, 5'd0, 1'b1, 5'd0);
    step("t3_wr0");
    set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    #1;
    check("t3_lit/rdata1", bus.rdata1, 32'd0);
    check("t3_lit/wb_cnt", bus.wb_cnt, 32'd1);
    step("t3_rd0");

    // Same-cycle write and read of r9.
    set_wr(1'b1, 5'd9, 32'h11, 1'b0, 32'd0, 32'd0);
    set_rd(1'b1, 5'd9, 1'b1, 5'd9);
    step("t4_old");
    set_wr(1'b1, 5'd9, 32'h22, 1'b0, 32'd0, 32'd0);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    check("t4_same/rdata1", bus.rdata1, 32'h22);
`else
    check("t4_same/rdata1", bus.rdata1, 32'h11);
`endif
    step("t4_new");
    set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    #1;
    check("t4_next/rdata2", bus.rdata2, 32'h22);
    step("t4_next");

    // HI/LO and GPR written together count once.
    cnt_before = m_cnt;
    set_wr(1'b1, 5'd3, 32'hCAFE0003, 1'b1, 32'hA, 32'hB);
    set_rd(1'b1, 5'd3, 1'b0, 5'd0);
    step("t5_wr");
    set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    #1;
    check("t5_lit/hi_o",   bus.hi_o,   32'hA);
    check("t5_lit/lo_o",   bus.lo_o,   32'hB);
    check("t5_lit/rdata1", bus.rdata1, 32'hCAFE0003);
    check("t5_lit/wb_cnt", bus.wb_cnt, cnt_before + 32'd1);
    step("t5_rd");

    // Random traffic, half the time confined to a few registers to provoke collisions.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] amax;
      amax = ($urandom_range(0, 1) == 0) ? 5'd3 : 5'd31;
      set_wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, int'(amax))), $urandom(),
             ($urandom_range(0, 3) == 0), $urandom(), $urandom());
      set_rd(($urandom_range(0, 3) != 0), 5'($urandom_range(0, int'(amax))),
             ($urandom_range(0, 3) != 0), 5'($urandom_range(0, int'(amax))));
      step("rand");
    end

    // Counter wrap on the 3-bit instance: 7 writes reach all-ones, the 8th wraps to 0.
    set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    sbus.we = 1'b1; sbus.waddr = 5'd1; sbus.wdata = 32'h1;
    for (int n = 0; n < 7; n++) step("t6_fill");
    #1;
    check("t6_lit/full", 32'(sbus.wb_cnt), 32'd7);
    step("t6_wrap");
    sbus.we = 1'b0;
    #1;
    check("t6_lit/wrapped", 32'(sbus.wb_cnt), 32'd0);
    step("t6_bubble");
    #1;
    check("t6_lit/bubble", 32'(sbus.wb_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
